// File: rtl/reservation_station_pkg.sv
// Shared widths, micro-op encodings and entry/issue record types for the reservation station.
package reservation_station_pkg;

    localparam int WORD_W      = 32;
    localparam int INST_W      = 6;
    localparam int TAG_W       = 4;
    localparam int RS_SIZE_DEF = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [TAG_W-1:0]  tag_t;

    typedef enum logic [INST_W-1:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_ADDI = 6'd3,
        OP_AND  = 6'd4,
        OP_OR   = 6'd5,
        OP_XOR  = 6'd6,
        OP_SLL  = 6'd7,
        OP_SRL  = 6'd8,
        OP_SLT  = 6'd9,
        OP_BEQ  = 6'd10,
        OP_BNE  = 6'd11,
        OP_JAL  = 6'd12,
        OP_JALR = 6'd13
    } op_e;

    typedef struct packed {
        logic  r;
        word_t v;
        tag_t  q;
    } operand_t;

    typedef struct packed {
        logic  sig;
        word_t res;
        tag_t  tag;
    } cdb_t;

    typedef struct packed {
        logic              busy;
        logic [INST_W-1:0] op;
        word_t             imm;
        word_t             pc;
        tag_t              dest;
        operand_t          s1;
        operand_t          s2;
    } entry_t;

    typedef struct packed {
        logic              calc;
        logic [INST_W-1:0] op;
        word_t             imm;
        word_t             pc;
        word_t             rs1;
        word_t             rs2;
        tag_t              dest;
    } issue_t;

    // A waiting operand captures whichever bus broadcasts its producer tag.
    function automatic operand_t snoop(operand_t o, cdb_t alu, cdb_t lsb);
        operand_t res;
        res = o;
        if (!o.r) begin
            if (alu.sig && alu.tag == o.q) begin
                res.r = 1'b1;
                res.v = alu.res;
            end else if (lsb.sig && lsb.tag == o.q) begin
                res.r = 1'b1;
                res.v = lsb.res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Rename-side dispatch, CDB snoop and ALU issue signals of the reservation station.
// Handshake: a dispatch is accepted on a clock edge where dispatch_signal_in=1, full_out=0, flush_in=0 and rdy_in=1; alu_calculate_signal_out is a one-cycle valid with no back-pressure.
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic              dispatch_signal_in;
    logic [INST_W-1:0] dispatch_op_in;
    word_t             imm_in;
    word_t             pc_in;
    tag_t              dest_in;
    logic              dispatch_q1_ready_in;
    word_t             dispatch_v1_in;
    tag_t              dispatch_q1_in;
    logic              dispatch_q2_ready_in;
    word_t             dispatch_v2_in;
    tag_t              dispatch_q2_in;
    logic              full_out;

    logic              alu_cdb_signal_in;
    word_t             alu_cdb_result_in;
    tag_t              alu_cdb_tag_in;
    logic              lsb_cdb_signal_in;
    word_t             lsb_cdb_result_in;
    tag_t              lsb_cdb_tag_in;
    logic              flush_in;

    logic              alu_calculate_signal_out;
    logic [INST_W-1:0] alu_op_out;
    word_t             alu_imm_out;
    word_t             alu_pc_out;
    word_t             alu_rs1val_out;
    word_t             alu_rs2val_out;
    tag_t              alu_dest_out;

    modport slave (
        input  dispatch_signal_in, dispatch_op_in, imm_in, pc_in, dest_in,
        input  dispatch_q1_ready_in, dispatch_v1_in, dispatch_q1_in,
        input  dispatch_q2_ready_in, dispatch_v2_in, dispatch_q2_in,
        input  alu_cdb_signal_in, alu_cdb_result_in, alu_cdb_tag_in,
        input  lsb_cdb_signal_in, lsb_cdb_result_in, lsb_cdb_tag_in, flush_in,
        output full_out, alu_calculate_signal_out, alu_op_out, alu_imm_out,
        output alu_pc_out, alu_rs1val_out, alu_rs2val_out, alu_dest_out
    );

    modport master (
        output dispatch_signal_in, dispatch_op_in, imm_in, pc_in, dest_in,
        output dispatch_q1_ready_in, dispatch_v1_in, dispatch_q1_in,
        output dispatch_q2_ready_in, dispatch_v2_in, dispatch_q2_in,
        output alu_cdb_signal_in, alu_cdb_result_in, alu_cdb_tag_in,
        output lsb_cdb_signal_in, lsb_cdb_result_in, lsb_cdb_tag_in, flush_in,
        input  full_out, alu_calculate_signal_out, alu_op_out, alu_imm_out,
        input  alu_pc_out, alu_rs1val_out, alu_rs2val_out, alu_dest_out
    );

endinterface

// File: rtl/reservation_station_rs_select_encoder.sv
// Lowest-index priority encoder: returns the first set bit of req_in and whether any was set.
module reservation_station_rs_select_encoder #(
    parameter int N = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_in,
    output logic [IDX_W-1:0] idx_out,
    output logic             found_out
);

    always_comb begin
        idx_out   = '0;
        found_out = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_in[i]) begin
                idx_out   = IDX_W'(i);
                found_out = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers micro-ops, snoops ALU/LSB CDBs for operands, issues one ready entry per cycle.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF
) (
    input logic                  clk_in,
    input logic                  rst_in,
    input logic                  rdy_in,
    reservation_station_if.slave bus
);

    localparam int IDX_W = $clog2(RS_SIZE);

    entry_t             ent_q [RS_SIZE];
    entry_t             ent_d [RS_SIZE];
    issue_t             iss_q;
    issue_t             iss_d;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   ready_idx;
    logic               free_found;
    logic               ready_found;
    logic               full;
    cdb_t               alu_cdb;
    cdb_t               lsb_cdb;
    operand_t           disp_s1;
    operand_t           disp_s2;

    assign alu_cdb = {bus.alu_cdb_signal_in, bus.alu_cdb_result_in, bus.alu_cdb_tag_in};
    assign lsb_cdb = {bus.lsb_cdb_signal_in, bus.lsb_cdb_result_in, bus.lsb_cdb_tag_in};
    assign disp_s1 = snoop({bus.dispatch_q1_ready_in, bus.dispatch_v1_in, bus.dispatch_q1_in},
                           alu_cdb, lsb_cdb);
    assign disp_s2 = snoop({bus.dispatch_q2_ready_in, bus.dispatch_v2_in, bus.dispatch_q2_in},
                           alu_cdb, lsb_cdb);

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && ent_q[i].s1.r && ent_q[i].s2.r;
        end
    end

    reservation_station_rs_select_encoder #(.N(RS_SIZE)) u_free_sel (
        .req_in   (free_vec),
        .idx_out  (free_idx),
        .found_out(free_found)
    );

    reservation_station_rs_select_encoder #(.N(RS_SIZE)) u_ready_sel (
        .req_in   (ready_vec),
        .idx_out  (ready_idx),
        .found_out(ready_found)
    );

    // Full reflects start-of-cycle occupancy; a slot freed by this cycle's issue is reusable next cycle.
    assign full = !free_found;

    always_comb begin
        ent_d = ent_q;
        iss_d = iss_q;
        if (rdy_in) begin
            if (bus.flush_in) begin
                for (int i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
                iss_d.calc = 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent_q[i].busy) begin
                        ent_d[i].s1 = snoop(ent_q[i].s1, alu_cdb, lsb_cdb);
                        ent_d[i].s2 = snoop(ent_q[i].s2, alu_cdb, lsb_cdb);
                    end
                end
                iss_d.calc = ready_found;
                if (ready_found) begin
                    iss_d.op              = ent_q[ready_idx].op;
                    iss_d.imm             = ent_q[ready_idx].imm;
                    iss_d.pc              = ent_q[ready_idx].pc;
                    iss_d.rs1             = ent_q[ready_idx].s1.v;
                    iss_d.rs2             = ent_q[ready_idx].s2.v;
                    iss_d.dest            = ent_q[ready_idx].dest;
                    ent_d[ready_idx].busy = 1'b0;
                end
                if (bus.dispatch_signal_in && !full) begin
                    ent_d[free_idx].busy = 1'b1;
                    ent_d[free_idx].op   = bus.dispatch_op_in;
                    ent_d[free_idx].imm  = bus.imm_in;
                    ent_d[free_idx].pc   = bus.pc_in;
                    ent_d[free_idx].dest = bus.dest_in;
                    ent_d[free_idx].s1   = disp_s1;
                    ent_d[free_idx].s2   = disp_s2;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
            iss_q <= '0;
        end else begin
            ent_q <= ent_d;
            iss_q <= iss_d;
        end
    end

    assign bus.full_out                 = full;
    assign bus.alu_calculate_signal_out = iss_q.calc;
    assign bus.alu_op_out               = iss_q.op;
    assign bus.alu_imm_out              = iss_q.imm;
    assign bus.alu_pc_out               = iss_q.pc;
    assign bus.alu_rs1val_out           = iss_q.rs1;
    assign bus.alu_rs2val_out           = iss_q.rs2;
    assign bus.alu_dest_out             = iss_q.dest;

    a_no_dispatch_when_full: assert property (@(posedge clk_in) disable iff (!rst_in)
        !(rdy_in && !bus.flush_in && bus.dispatch_signal_in && full));

    a_cdb_tags_distinct: assert property (@(posedge clk_in) disable iff (!rst_in)
        !(rdy_in && bus.alu_cdb_signal_in && bus.lsb_cdb_signal_in &&
          bus.alu_cdb_tag_in == bus.lsb_cdb_tag_in));

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: directed scenarios plus random traffic against a behavioural model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int N = RS_SIZE_DEF;

    typedef struct packed {
        logic rdy; logic flush; logic disp;
        logic [INST_W-1:0] op; word_t imm; word_t pc; tag_t dest;
        logic r1; word_t v1; tag_t q1;
        logic r2; word_t v2; tag_t q2;
        logic a_sig; word_t a_res; tag_t a_tag;
        logic l_sig; word_t l_res; tag_t l_tag;
    } stim_t;

    typedef struct packed {
        logic calc; logic [INST_W-1:0] op; word_t imm; word_t pc;
        word_t rs1; word_t rs2; tag_t dest; logic full;
    } exp_t;

    typedef struct {
        bit busy; logic [INST_W-1:0] op; word_t imm; word_t pc; tag_t dest;
        bit r1; word_t v1; tag_t q1; bit r2; word_t v2; tag_t q2;
    } m_ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    m_ent_t m_rs[N];
    exp_t m_out;

    reservation_station_if bus();

    reservation_station #(.RS_SIZE(N)) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .rdy_in(rdy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    function automatic bit cdb_hit(input stim_t s, input tag_t q, output word_t val);
        val = '0;
        if (s.a_sig && s.a_tag == q) begin val = s.a_res; return 1'b1; end
        if (s.l_sig && s.l_tag == q) begin val = s.l_res; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic bit model_full();
        foreach (m_rs[i]) if (!m_rs[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        foreach (m_rs[i]) m_rs[i].busy = 1'b0;
        m_out = '0;
    endfunction

    // Reference behaviour for one clock edge given the inputs held during that cycle.
    function automatic void model_step(input stim_t s);
        int sel = -1;
        int fr = -1;
        word_t val;
        if (!s.rdy) return;
        if (s.flush) begin
            foreach (m_rs[i]) m_rs[i].busy = 1'b0;
            m_out.calc = 1'b0;
            m_out.full = 1'b0;
            return;
        end
        foreach (m_rs[i]) begin
            if (sel < 0 && m_rs[i].busy && m_rs[i].r1 && m_rs[i].r2) sel = i;
            if (fr < 0 && !m_rs[i].busy) fr = i;
        end
        foreach (m_rs[i]) begin
            if (m_rs[i].busy && !m_rs[i].r1 && cdb_hit(s, m_rs[i].q1, val)) begin
                m_rs[i].r1 = 1'b1; m_rs[i].v1 = val;
            end
            if (m_rs[i].busy && !m_rs[i].r2 && cdb_hit(s, m_rs[i].q2, val)) begin
                m_rs[i].r2 = 1'b1; m_rs[i].v2 = val;
            end
        end
        if (sel >= 0) begin
            m_out.calc = 1'b1;
            m_out.op   = m_rs[sel].op;
            m_out.imm  = m_rs[sel].imm;
            m_out.pc   = m_rs[sel].pc;
            m_out.rs1  = m_rs[sel].v1;
            m_out.rs2  = m_rs[sel].v2;
            m_out.dest = m_rs[sel].dest;
            m_rs[sel].busy = 1'b0;
        end else begin
            m_out.calc = 1'b0;
        end
        if (s.disp && fr >= 0) begin
            m_rs[fr].busy = 1'b1;
            m_rs[fr].op = s.op; m_rs[fr].imm = s.imm; m_rs[fr].pc = s.pc; m_rs[fr].dest = s.dest;
            m_rs[fr].r1 = s.r1; m_rs[fr].v1 = s.v1; m_rs[fr].q1 = s.q1;
            m_rs[fr].r2 = s.r2; m_rs[fr].v2 = s.v2; m_rs[fr].q2 = s.q2;
            if (!s.r1 && cdb_hit(s, s.q1, val)) begin m_rs[fr].r1 = 1'b1; m_rs[fr].v1 = val; end
            if (!s.r2 && cdb_hit(s, s.q2, val)) begin m_rs[fr].r2 = 1'b1; m_rs[fr].v2 = val; end
        end
        m_out.full = model_full();
    endfunction

    task automatic apply(input stim_t s);
        rdy                      = s.rdy;
        bus.flush_in             = s.flush;
        bus.dispatch_signal_in   = s.disp;
        bus.dispatch_op_in       = s.op;
        bus.imm_in               = s.imm;
        bus.pc_in                = s.pc;
        bus.dest_in              = s.dest;
        bus.dispatch_q1_ready_in = s.r1;
        bus.dispatch_v1_in       = s.v1;
        bus.dispatch_q1_in       = s.q1;
        bus.dispatch_q2_ready_in = s.r2;
        bus.dispatch_v2_in       = s.v2;
        bus.dispatch_q2_in       = s.q2;
        bus.alu_cdb_signal_in    = s.a_sig;
        bus.alu_cdb_result_in    = s.a_res;
        bus.alu_cdb_tag_in       = s.a_tag;
        bus.lsb_cdb_signal_in    = s.l_sig;
        bus.lsb_cdb_result_in    = s.l_res;
        bus.lsb_cdb_tag_in       = s.l_tag;
    endtask

    task automatic tick(input stim_t s);
        @(negedge clk);
        apply(s);
        model_step(s);
        @(posedge clk);
        exp_q.push_back(m_out);
    endtask

    task automatic dispatch(input logic [INST_W-1:0] op, input bit r1, input word_t v1,
                            input tag_t q1, input bit r2, input word_t v2, input tag_t q2,
                            input tag_t dest);
        stim_t s;
        s = idle();
        s.disp = 1'b1; s.op = op; s.imm = 32'h100 + 32'(dest); s.pc = 32'h8000 + 32'(dest);
        s.dest = dest; s.r1 = r1; s.v1 = v1; s.q1 = q1; s.r2 = r2; s.v2 = v2; s.q2 = q2;
        tick(s);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_calc"}, 32'(bus.alu_calculate_signal_out), 32'd0);
        check({tag, "_full"}, 32'(bus.full_out), 32'd0);
        check({tag, "_op"},   32'(bus.alu_op_out), 32'd0);
        check({tag, "_imm"},  bus.alu_imm_out, 32'd0);
        check({tag, "_pc"},   bus.alu_pc_out, 32'd0);
        check({tag, "_rs1"},  bus.alu_rs1val_out, 32'd0);
        check({tag, "_rs2"},  bus.alu_rs2val_out, 32'd0);
        check({tag, "_dest"}, 32'(bus.alu_dest_out), 32'd0);
    endtask

    // Monitor: one expected record per clock edge, compared half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("calc", 32'(bus.alu_calculate_signal_out), 32'(e.calc));
                check("full", 32'(bus.full_out), 32'(e.full));
                check("op",   32'(bus.alu_op_out), 32'(e.op));
                check("imm",  bus.alu_imm_out, e.imm);
                check("pc",   bus.alu_pc_out, e.pc);
                check("rs1",  bus.alu_rs1val_out, e.rs1);
                check("rs2",  bus.alu_rs2val_out, e.rs2);
                check("dest", 32'(bus.alu_dest_out), 32'(e.dest));
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        stim_t s;
        s = idle();
        s.rdy = 1'b0;
        apply(s);
        model_reset();
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Ready ADD issues on the following edge, then the issue valid drops.
        dispatch(OP_ADD, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
        tick(idle());
        tick(idle());

        // ADDI waiting on tag 4, woken by an ALU broadcast two cycles later.
        dispatch(OP_ADDI, 1'b0, 32'd0, 4'd4, 1'b1, 32'd0, 4'd0, 4'd5);
        tick(idle());
        s = idle(); s.a_sig = 1'b1; s.a_tag = 4'd4; s.a_res = 32'h10;
        tick(s);
        tick(idle());
        tick(idle());

        // rs2 bypassed from the LSB bus in the dispatch cycle.
        s = idle();
        s.disp = 1'b1; s.op = OP_SUB; s.dest = 4'd8; s.r1 = 1'b1; s.v1 = 32'd1;
        s.r2 = 1'b0; s.q2 = 4'd6; s.l_sig = 1'b1; s.l_tag = 4'd6; s.l_res = 32'hDEAD;
        tick(s);
        tick(idle());
        tick(idle());

        // Fill every slot, then wake only entry 0.
        for (int i = 0; i < N; i++)
            dispatch(OP_SUB, 1'b0, 32'd0, (i == 0) ? 4'd1 : 4'd9, 1'b1, 32'(i), 4'd0, 4'(i));
        tick(idle());
        s = idle(); s.a_sig = 1'b1; s.a_tag = 4'd1; s.a_res = 32'h77;
        tick(s);
        tick(idle());
        tick(idle());
        s = idle(); s.flush = 1'b1;
        tick(s);

        // Flush with eight busy entries and an issue pending; dispatch in the same cycle is ignored.
        for (int i = 0; i < 7; i++)
            dispatch(OP_AND, 1'b0, 32'd0, 4'd9, 1'b1, 32'(i), 4'd0, 4'(i));
        dispatch(OP_OR, 1'b1, 32'h33, 4'd0, 1'b1, 32'h44, 4'd0, 4'd12);
        s = idle(); s.flush = 1'b1; s.disp = 1'b1; s.r1 = 1'b1; s.r2 = 1'b1; s.dest = 4'd13;
        tick(s);
        tick(idle());
        s = idle(); s.a_sig = 1'b1; s.a_tag = 4'd9; s.a_res = 32'h99;
        tick(s);
        tick(idle());

        // Entries 2 and 5 become ready together; lower index wins.
        for (int i = 0; i < 6; i++)
            dispatch(OP_XOR, 1'b0, 32'd0, (i == 2 || i == 5) ? 4'd7 : 4'd11,
                     1'b1, 32'(i), 4'd0, 4'(i + 1));
        s = idle(); s.a_sig = 1'b1; s.a_tag = 4'd7; s.a_res = 32'hABC;
        tick(s);
        tick(idle());
        tick(idle());
        tick(idle());
        s = idle(); s.flush = 1'b1;
        tick(s);

        // Random traffic, including stalls and occasional flushes.
        for (int c = 0; c < 400; c++) begin
            s = idle();
            s.rdy   = ($urandom_range(0, 9) != 0);
            s.flush = ($urandom_range(0, 49) == 0);
            s.disp  = ($urandom_range(0, 9) < 6) && !model_full();
            s.op    = INST_W'($urandom_range(0, 13));
            s.imm   = $urandom; s.pc = $urandom;
            s.dest  = TAG_W'($urandom_range(0, 15));
            s.r1    = 1'($urandom_range(0, 1)); s.v1 = $urandom; s.q1 = TAG_W'($urandom_range(0, 15));
            s.r2    = 1'($urandom_range(0, 1)); s.v2 = $urandom; s.q2 = TAG_W'($urandom_range(0, 15));
            s.a_sig = ($urandom_range(0, 2) == 0); s.a_res = $urandom; s.a_tag = TAG_W'($urandom_range(0, 15));
            s.l_sig = ($urandom_range(0, 2) == 0); s.l_res = $urandom; s.l_tag = TAG_W'($urandom_range(0, 15));
            if (s.a_sig && s.l_sig && s.a_tag == s.l_tag) s.l_sig = 1'b0;
            tick(s);
        end

        // Asynchronous reset between edges with work in flight.
        for (int i = 0; i < 3; i++)
            dispatch(OP_ADD, 1'b1, 32'(i + 20), 4'd0, 1'b1, 32'd1, 4'd0, 4'(i + 2));
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        model_reset();
        apply(idle());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        dispatch(OP_ADD, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
        tick(idle());
        tick(idle());
        @(negedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
